// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the frame checker and the transmit-side generator.
package crc8_pkg;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;
    localparam int LEN_W = 16;
    localparam int ERR_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One byte through the MSB-first LFSR, unrolled into a pure XOR network.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_byte_step.sv
// Combinational one-byte CRC-8 next-state network, same XOR tree as the generator.
module crc8_byte_step
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY
) (
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] next
);

    assign next = crc8_step(crc, data, POLY);

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: runs the LFSR over payload plus CRC byte and
// posts a held pass/fail result with frame length and a saturating error count.
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY,
    parameter logic [7:0] INIT = CRC_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             res_ok,
    output logic [LEN_W-1:0] res_len,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state, state_nxt;
    logic [7:0]       crc, crc_nxt, step_base, step_out;
    logic [LEN_W-1:0] len, len_nxt;
    logic             xfer, post, abort, frame_ok;
    logic [ERR_W:0]   err_sum;

    // Only an eof byte can stall, and only behind an unacknowledged result.
    assign in_ready = !(res_valid && !res_ack && in_eof && in_valid);
    assign xfer     = in_valid && in_ready;

    // A start-of-frame byte always seeds the LFSR from INIT, even mid-frame.
    assign step_base = (state == IDLE || in_sof) ? INIT : crc;

    crc8_byte_step #(.POLY(POLY)) u_step (
        .crc  (step_base),
        .data (in_data),
        .next (step_out)
    );

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc;
        len_nxt   = len;
        post      = 1'b0;
        abort     = 1'b0;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (in_sof) begin
                        crc_nxt   = step_out;
                        len_nxt   = LEN_ONE;
                        post      = in_eof;
                        state_nxt = in_eof ? IDLE : BUSY;
                    end
                end
                BUSY: begin
                    abort   = in_sof;
                    crc_nxt = step_out;
                    if (in_sof)          len_nxt = LEN_ONE;
                    else if (len != LEN_MAX) len_nxt = len + LEN_ONE;
                    if (in_eof) begin
                        post      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        frame_ok = (crc_nxt == 8'h00) && (len_nxt >= LEN_W'(2));
        // An aborting sof that is also eof counts twice: abort plus runt.
        err_sum  = {1'b0, err_cnt} + (ERR_W+1)'(abort) + (ERR_W+1)'(post && !frame_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            crc   <= INIT;
            len   <= '0;
        end else begin
            state <= state_nxt;
            crc   <= crc_nxt;
            len   <= len_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            res_len   <= '0;
            err_cnt   <= '0;
        end else begin
            if (post) begin
                res_valid <= 1'b1;
                res_ok    <= frame_ok;
                res_len   <= len_nxt;
            end else if (res_valid && res_ack) begin
                res_valid <= 1'b0;
            end
            err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        end
    end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed self-checking bench for crc8_frame_checker.
module tb_crc8_frame_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sof, in_eof;
    logic [7:0]  in_data;
    logic        res_valid, res_ack, res_ok;
    logic [15:0] res_len;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] good [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                              8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};

    crc8_frame_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .res_valid (res_valid),
        .res_ack   (res_ack),
        .res_ok    (res_ok),
        .res_len   (res_len),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte at the falling edge and hold it until it is accepted.
    task automatic send(input logic [7:0] d, input logic s, input logic e);
        logic rdy;
        int   stalls;
        stalls = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e;
        forever begin
            #1 rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            stalls++;
            if (stalls > 20) begin
                chk("send_stall_timeout", 32'(stalls), 32'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
    endtask

    task automatic send_frame(input bit corrupt);
        logic [7:0] d;
        for (int i = 0; i < 10; i++) begin
            d = (corrupt && i == 4) ? 8'h36 : good[i];
            send(d, i == 0, i == 9);
        end
    endtask

    task automatic ack_res();
        @(negedge clk);
        res_ack = 1'b1;
        @(posedge clk);
        #1 res_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_data = 8'h00; res_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_ok", 32'(res_ok), 32'd0);
        chk("rst_res_len", 32'(res_len), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // Good frame: "123456789" + CRC 0xF4
        send_frame(1'b0);
        idle();
        chk("good_valid", 32'(res_valid), 32'd1);
        chk("good_ok", 32'(res_ok), 32'd1);
        chk("good_len", 32'(res_len), 32'd10);
        chk("good_err", 32'(err_cnt), 32'd0);
        ack_res();
        @(negedge clk);
        chk("ack_clears_valid", 32'(res_valid), 32'd0);

        // Corrupt frame
        send_frame(1'b1);
        idle();
        chk("bad_valid", 32'(res_valid), 32'd1);
        chk("bad_ok", 32'(res_ok), 32'd0);
        chk("bad_len", 32'(res_len), 32'd10);
        chk("bad_err", 32'(err_cnt), 32'd1);
        ack_res();

        // Runt: single sof+eof byte
        send(8'h00, 1'b1, 1'b1);
        idle();
        chk("runt_valid", 32'(res_valid), 32'd1);
        chk("runt_ok", 32'(res_ok), 32'd0);
        chk("runt_len", 32'(res_len), 32'd1);
        chk("runt_err", 32'(err_cnt), 32'd2);
        ack_res();

        // Abort: three bytes, then a good frame starting with sof mid-frame
        send(8'hAA, 1'b1, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b0, 1'b0);
        send_frame(1'b0);
        idle();
        chk("abort_valid", 32'(res_valid), 32'd1);
        chk("abort_ok", 32'(res_ok), 32'd1);
        chk("abort_len", 32'(res_len), 32'd10);
        chk("abort_err", 32'(err_cnt), 32'd3);
        ack_res();

        // Backpressure: two good frames back-to-back, ack held low
        send_frame(1'b0);
        for (int i = 0; i < 9; i++) send(good[i], i == 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hF4; in_sof = 1'b0; in_eof = 1'b1;
        #1;
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        chk("bp_first_held", 32'(res_valid), 32'd1);
        @(negedge clk);
        chk("bp_stall_ready2", 32'(in_ready), 32'd0);
        chk("bp_first_ok", 32'(res_ok), 32'd1);
        res_ack = 1'b1;
        #1;
        chk("bp_ack_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 res_ack = 1'b0;
        idle();
        chk("bp_second_valid", 32'(res_valid), 32'd1);
        chk("bp_second_ok", 32'(res_ok), 32'd1);
        chk("bp_second_len", 32'(res_len), 32'd10);
        chk("bp_err", 32'(err_cnt), 32'd3);
        ack_res();
        @(negedge clk);
        chk("bp_acked", 32'(res_valid), 32'd0);

        // Reset mid-frame with a failed result pending
        send_frame(1'b1);
        for (int i = 0; i < 4; i++) send(good[i], i == 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_eof = 1'b1; in_sof = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_len", 32'(res_len), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0; in_eof = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 4; i < 10; i++) send(good[i], 1'b0, i == 9);
        idle();
        chk("tail_dropped_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("tail_dropped_valid2", 32'(res_valid), 32'd0);
        chk("tail_dropped_err", 32'(err_cnt), 32'd0);

        // Saturation: 260 corrupt frames with ack held high
        res_ack = 1'b1;
        for (int f = 0; f < 260; f++) send_frame(1'b1);
        idle();
        chk("sat_err", 32'(err_cnt), 32'hFF);
        chk("sat_ok", 32'(res_ok), 32'd0);

        // 70000-byte all-zero frame: length saturates, CRC of zeros stays 0
        send(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 69998; i++) send(8'h00, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        idle();
        chk("long_valid", 32'(res_valid), 32'd1);
        chk("long_len", 32'(res_len), 32'hFFFF);
        chk("long_ok", 32'(res_ok), 32'd1);
        chk("long_err", 32'(err_cnt), 32'hFF);
        res_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc8_frame_checker.md
# crc8_frame_checker

Receive-side CRC-8 frame checker that pairs with the XOR-tree CRC generator on the transmit path. It accepts a byte stream delimited by start/end-of-frame markers and runs an 8-bit LFSR over every byte, with the trailing byte being the transmitted CRC. At end of frame it posts a held pass/fail result with the frame length, and keeps a saturating error count. It sits between the byte deserializer and the frame buffer controller in the SoC datapath.

## Interface
- POLY, 8'h07, CRC generator polynomial (x^8 term implicit), MSB-first.
- INIT, 8'h00, LFSR preset applied at each start of frame.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_sof/in_eof are valid this cycle.
- in_ready  output  1  checker accepts the byte; a transfer occurs when in_valid & in_ready.
- in_data  input  8  payload or CRC byte.
- in_sof  input  1  first byte of a frame.
- in_eof  input  1  last byte of a frame, which is the CRC byte.
- res_valid  output  1  result held and pending.
- res_ack  input  1  consumer takes the result.
- res_ok  output  1  frame passed the check.
- res_len  output  16  bytes in the frame, CRC byte included, saturating at 16'hFFFF.
- err_cnt  output  8  failed, runt, and aborted frames, saturating at 8'hFF.

## Operation
- FSM states are IDLE and BUSY.
- **IDLE.** Bytes without sof are dropped and are not counted. A transfer with sof sets crc = step(INIT, data) and len = 1, then moves to BUSY. If eof is also set, the frame is handled as a runt (see below).
- **BUSY.** Each transfer sets crc = step(crc, data) and len = sat(len + 1).
  - eof: latch the result and return to IDLE.
  - sof: abort the current frame. err_cnt increments and the frame restarts with this byte. No result is posted for the aborted frame.
- **step.** An 8-iteration unrolled MSB-first shift with a conditional XOR of POLY. It is purely combinational, so a byte is processed in one cycle.
- **Check rule.** Because there is no final XOR, the CRC run over payload plus received CRC equals 8'h00 for a good frame.
  - res_ok = (final crc == 0) && (len >= 2).
  - len < 2 is a runt: res_ok = 0.
- **Result latch.** Sets res_valid = 1 together with res_ok and res_len. These hold until res_ack is sampled while res_valid = 1.
- **Error count.** err_cnt increments on every res_ok = 0 posting and on every abort, saturating.
- **Backpressure.**
  - in_ready = !(res_valid && !res_ack && in_eof && in_valid). An eof byte stalls while an unacknowledged result is pending.
  - Non-eof bytes are always accepted.
  - res_ack in the same cycle as an eof transfer frees the latch, and the new result loads that cycle.
- res_ack while res_valid = 0 is ignored.
- **Reset (asynchronous, any state, mid-frame included).**
  - State returns to IDLE.
  - crc = INIT, len = 0.
  - res_valid = 0, res_ok = 0, res_len = 0, err_cnt = 0.
  - in_ready = 1.

## Timing
- in_ready is combinational from in_valid, in_eof, res_valid, and res_ack. All other outputs are registered.
- Latency: res_valid rises on the clock edge that accepts the eof byte and is visible the following cycle.
- res_valid falls on the edge where res_ack = 1 is sampled, unless a new eof is accepted on that same edge; in that case it stays high with the new values.
- Throughput is one byte per cycle, including back-to-back frames with sof on the byte immediately after eof.
- err_cnt and res_* update on the same edge.

## Structure
- Package crc8_pkg holds:
  - the POLY/INIT defaults,
  - the state enum type (IDLE, BUSY),
  - the widths LEN_W = 16 and ERR_W = 8,
  - a crc8_step function that the generator shares.
- One sub-module: crc8_byte_step, a combinational 8-bit next-state network instantiated once. It mirrors the generator's XOR tree so synthesis maps it onto XOR2X1 cells.

## Test plan
- **Good frame.** Bytes 8'h31..8'h39 ("123456789") with sof on the first, then 8'hF4 with eof, no stalls. Required: res_valid = 1 one cycle later, res_ok = 1, res_len = 10, err_cnt = 0.
- **Corrupt frame.** The same frame with the 5th byte changed to 8'h36. Required: res_ok = 0, res_len = 10, err_cnt = 1.
- **Runt and abort.**
  - A single byte 8'h00 with sof and eof. Required: res_ok = 0, res_len = 1.
  - Then 3 bytes followed by sof mid-frame, then a good 10-byte frame. Required: err_cnt increments by 2 in total, and the final result is res_ok = 1 with res_len = 10.
- **Backpressure.** The good frame is repeated twice back-to-back with res_ack held low. Required: the second eof sees in_ready = 0 and the first result is held. Pulsing res_ack: the second eof transfers that same cycle and the second result (res_ok = 1) appears.
- **Reset mid-frame.** Assert reset after byte 4 of a frame. Required: all outputs cleared immediately, without waiting for a clock edge. The rest of that frame, sent without sof, is dropped and produces no res_valid.
- **Saturation.** Send 260 corrupt frames. Required: err_cnt stays at 8'hFF. A frame of 70000 bytes reports res_len = 16'hFFFF.
